ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Time-slotted RAM arbiter: CPU/video slots framed by RAM_en, debug port fills unused slots.
// Each granted slot runs IDLE -> ACCESS -> CAPTURE; RAM read data is captured at the end of CAPTURE.
module ram_arbiter #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 8
) (
  input  logic          PIXELCLK,
  input  logic          RESET,
  input  logic          RAM_en,
  input  logic          PROC_en,
  input  logic          CPU_sel,
  input  logic          CPU_wr,
  input  logic [AW-1:0] CPU_addr,
  input  logic [DW-1:0] CPU_din,
  output logic [DW-1:0] CPU_dout,
  input  logic          VID_req,
  input  logic [AW-1:0] VID_addr,
  output logic [DW-1:0] VID_data,
  output logic          VID_valid,
  input  logic          DBG_req,
  input  logic          DBG_wr,
  input  logic [AW-1:0] DBG_addr,
  input  logic [DW-1:0] DBG_din,
  output logic [DW-1:0] DBG_dout,
  output logic          DBG_ack,
  output logic [AW-1:0] RAM_addr,
  output logic          RAM_we,
  output logic [DW-1:0] RAM_wdata,
  input  logic [DW-1:0] RAM_rdata,
  output logic [1:0]    GRANT,
  output logic          SLOT_ERR
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_VID  = 2'b10;
  localparam logic [1:0] G_DBG  = 2'b11;

  state_t     state;
  state_t     next_state;
  logic [1:0] sel_owner;
  logic       overrun;
  logic       dbg_ok;
  logic       is_wr;

  // A request still high while its ack is out is the tail of the old transaction.
  assign dbg_ok = DBG_req && !DBG_ack;

  always_ff @(posedge PIXELCLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Owner selection and slot sequencing
  always_comb begin
    next_state = state;
    sel_owner  = G_NONE;
    overrun    = 1'b0;
    case (state)
      IDLE: begin
        if (RAM_en) begin
          if (PROC_en) begin
            if (CPU_sel)     sel_owner = G_CPU;
            else if (dbg_ok) sel_owner = G_DBG;
          end else begin
            if (VID_req)     sel_owner = G_VID;
            else if (dbg_ok) sel_owner = G_DBG;
          end
          if (sel_owner != G_NONE) next_state = ACCESS;
        end
      end
      ACCESS: begin
        next_state = CAPTURE;
        overrun    = RAM_en;
      end
      CAPTURE: begin
        next_state = IDLE;
        overrun    = RAM_en;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered RAM request, read-data capture and completion strobes
  always_ff @(posedge PIXELCLK) begin
    if (RESET) begin
      RAM_addr  <= AW'(0);
      RAM_we    <= 1'b0;
      RAM_wdata <= DW'(0);
      GRANT     <= G_NONE;
      is_wr     <= 1'b0;
      CPU_dout  <= DW'(0);
      VID_data  <= DW'(0);
      DBG_dout  <= DW'(0);
      VID_valid <= 1'b0;
      DBG_ack   <= 1'b0;
      SLOT_ERR  <= 1'b0;
    end else begin
      RAM_we    <= 1'b0;
      VID_valid <= 1'b0;
      DBG_ack   <= 1'b0;
      if (overrun) SLOT_ERR <= 1'b1;
      case (state)
        IDLE: begin
          if (sel_owner != G_NONE) GRANT <= sel_owner;
          case (sel_owner)
            G_CPU: begin
              RAM_addr <= CPU_addr;
              RAM_we   <= CPU_wr;
              is_wr    <= CPU_wr;
              if (CPU_wr) RAM_wdata <= CPU_din;
            end
            G_VID: begin
              RAM_addr <= VID_addr;
              is_wr    <= 1'b0;
            end
            G_DBG: begin
              RAM_addr <= DBG_addr;
              RAM_we   <= DBG_wr;
              is_wr    <= DBG_wr;
              if (DBG_wr) RAM_wdata <= DBG_din;
            end
            default: ;
          endcase
        end
        CAPTURE: begin
          GRANT     <= G_NONE;
          VID_valid <= (GRANT == G_VID);
          DBG_ack   <= (GRANT == G_DBG);
          if (!is_wr) begin
            case (GRANT)
              G_CPU:   CPU_dout <= RAM_rdata;
              G_VID:   VID_data <= RAM_rdata;
              G_DBG:   DBG_dout <= RAM_rdata;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
